// File: rtl/sdft_pkg.sv
// +----------------------------------------------------------------------------+
// | sdft_pkg : shared types and arithmetic helpers for the sliding-DFT engine  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package sdft_pkg;

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_IDLE  = 3'd1,
    S_DELTA = 3'd2,
    S_CALC  = 3'd3,
    S_DRAIN = 3'd4,
    S_READ  = 3'd5
  } state_e;

  function automatic int aw_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Round half up, then arithmetic shift.
  function automatic longint rnd_f(input longint x, input int sh);
    return (x + (longint'(1) <<< (sh - 1))) >>> sh;
  endfunction

  function automatic longint sat_f(input longint x, input int w);
    longint hi, lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    return (x > hi) ? hi : ((x < lo) ? lo : x);
  endfunction

  function automatic longint usat_f(input longint x, input int w);
    longint hi;
    hi = (longint'(1) <<< w) - 1;
    return (x > hi) ? hi : ((x < 0) ? 0 : x);
  endfunction

  function automatic longint mag_f(input longint re, input longint im);
    longint ar, ai;
    ar = (re < 0) ? -re : re;
    ai = (im < 0) ? -im : im;
    return (ar > ai) ? (ar + (ai >>> 1)) : (ai + (ar >>> 1));
  endfunction

  // Twiddle e^{+j*2*pi*k/n}, scaled by 2^(w-1)-1, rounded half away from zero.
  function automatic int tw_f(input int k, input int n, input int w, input bit imag);
    real ang, v;
    ang = 6.283185307179586 * real'(k) / real'(n);
    v   = (imag ? $sin(ang) : $cos(ang)) * real'((1 << (w - 1)) - 1);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sdft_engine_if.sv
// +----------------------------------------------------------------------------+
// | sdft_engine_if : sample/start and magnitude-read handshake bundle          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface sdft_engine_if #(
  parameter int DATA_W = 8,
  parameter int AW     = 9,
  parameter int OUT_W  = 16
);
  logic [DATA_W-1:0] sample;
  logic              start;
  logic              ready;
  logic              done;
  logic              rd_req;
  logic [AW-1:0]     rd_addr;
  logic              rd_valid;
  logic [OUT_W-1:0]  rd_data;

  modport master (
    output sample, start, rd_req, rd_addr,
    input  ready, done, rd_valid, rd_data
  );

  modport slave (
    input  sample, start, rd_req, rd_addr,
    output ready, done, rd_valid, rd_data
  );
endinterface

`default_nettype wire

// File: rtl/sdft_twiddle_rom.sv
// +----------------------------------------------------------------------------+
// | sdft_twiddle_rom : 1-cycle synchronous dual-output twiddle ROM             |
// | Rev 1.0  (image generated at elaboration, no initialisation files)         |
// +----------------------------------------------------------------------------+
`default_nettype none

module sdft_twiddle_rom
  import sdft_pkg::*;
#(
  parameter int N_BINS = 320,
  parameter int TW_W   = 8,
  parameter int AW     = 9
) (
  input  logic                   clk,
  input  logic [AW-1:0]          addr_i,
  output logic signed [TW_W-1:0] wr_o,
  output logic signed [TW_W-1:0] wi_o
);

  logic signed [TW_W-1:0] tab_re [N_BINS];
  logic signed [TW_W-1:0] tab_im [N_BINS];

  for (genvar k = 0; k < N_BINS; k++) begin : g_tw
    assign tab_re[k] = TW_W'(tw_f(k, N_BINS, TW_W, 1'b0));
    assign tab_im[k] = TW_W'(tw_f(k, N_BINS, TW_W, 1'b1));
  end

  always_ff @(posedge clk) begin
    wr_o <= tab_re[addr_i];
    wi_o <= tab_im[addr_i];
  end

endmodule

`default_nettype wire

// File: rtl/sdft_engine.sv
// +----------------------------------------------------------------------------+
// | sdft_engine : sliding-DFT engine, one bin per clock, magnitude read port   |
// | Rev 1.0  (optional macro SDFT_LEAK_EN adds a 1-2^-LEAK_SHIFT leak)         |
// +----------------------------------------------------------------------------+
`default_nettype none

module sdft_engine
  import sdft_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int N_BINS    = 320,
  parameter int TW_W      = 8,
  parameter int ACC_W     = 16,
  parameter int OUT_W     = 16,
  parameter int OUT_SHIFT = 7
`ifdef SDFT_LEAK_EN
  , parameter int LEAK_SHIFT = 8
`endif
) (
  input  logic       clk,
  input  logic       reset,
  sdft_engine_if.slave bus
);

  localparam int          AW   = aw_f(N_BINS);
  localparam logic [AW-1:0] LAST = AW'(N_BINS - 1);

  state_e                   state_q, state_d;
  logic [AW-1:0]            cnt_q, cnt_d;
  logic [AW-1:0]            idx_q, idx_d;
  logic [DATA_W-1:0]        sample_q, sample_d;
  logic                     oor_q, oor_d;
  logic                     done_q, done_d;
  logic                     rd_valid_q, rd_valid_d;
  logic [OUT_W-1:0]         rd_data_q, rd_data_d;
  logic                     s2_valid_q;
  logic [AW-1:0]            s2_addr_q;
  logic signed [DATA_W:0]   delta_q;
  logic [DATA_W-1:0]        hist_rd_q;
  logic signed [ACC_W-1:0]  re_rd_q, im_rd_q;
  logic signed [TW_W-1:0]   wr, wi;

  logic signed [ACC_W-1:0]  re_mem [N_BINS];
  logic signed [ACC_W-1:0]  im_mem [N_BINS];
  logic [DATA_W-1:0]        hist_mem [N_BINS];

  logic                     oor_now;
  logic [AW-1:0]            bin_raddr, bin_waddr;
  logic                     bin_we;
  logic signed [ACC_W-1:0]  re_wr, im_wr;
  logic [OUT_W-1:0]         mag_out;
  longint                   a_l, b_l, re_full, im_full;

  assign oor_now = (int'(bus.rd_addr) >= N_BINS);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_CLEAR;
      cnt_q      <= '0;
      idx_q      <= '0;
      sample_q   <= '0;
      oor_q      <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      s2_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sample_q   <= sample_d;
      oor_q      <= oor_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      s2_valid_q <= (state_q == S_CALC);
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    sample_d   = sample_q;
    oor_d      = oor_q;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    unique case (state_q)
      S_CLEAR: begin
        if (cnt_q == LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        // start wins; a simultaneous read is dropped, not deferred
        if (bus.start) begin
          state_d  = S_DELTA;
          sample_d = bus.sample;
        end else if (bus.rd_req) begin
          state_d = S_READ;
          oor_d   = oor_now;
        end
      end
      S_DELTA: begin
        state_d = S_CALC;
        cnt_d   = '0;
      end
      S_CALC: begin
        if (cnt_q == LAST) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        idx_d   = (idx_q == LAST) ? '0 : idx_q + 1'b1;
      end
      S_READ: begin
        state_d    = S_IDLE;
        rd_valid_d = 1'b1;
        rd_data_d  = oor_q ? '0 : mag_out;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // The read port shares the bin RAM read path; IDLE presents the read address.
  assign bin_raddr = (state_q == S_IDLE) ? (oor_now ? '0 : bus.rd_addr) : cnt_q;
  assign bin_we    = (state_q == S_CLEAR) || s2_valid_q;
  assign bin_waddr = (state_q == S_CLEAR) ? cnt_q : s2_addr_q;

  always_comb begin
    a_l = longint'(re_rd_q) + longint'(delta_q);
    b_l = longint'(im_rd_q);
`ifdef SDFT_LEAK_EN
    a_l = a_l - (a_l >>> LEAK_SHIFT);
    b_l = b_l - (b_l >>> LEAK_SHIFT);
`endif
    re_full = a_l * longint'(wr) - b_l * longint'(wi);
    im_full = a_l * longint'(wi) + b_l * longint'(wr);
    re_wr   = ACC_W'(sat_f(rnd_f(re_full, TW_W - 1), ACC_W));
    im_wr   = ACC_W'(sat_f(rnd_f(im_full, TW_W - 1), ACC_W));
    mag_out = OUT_W'(usat_f(mag_f(longint'(re_rd_q), longint'(im_rd_q)) >>> OUT_SHIFT, OUT_W));
  end

  always_ff @(posedge clk) begin
    if (bin_we) begin
      re_mem[bin_waddr] <= (state_q == S_CLEAR) ? '0 : re_wr;
      im_mem[bin_waddr] <= (state_q == S_CLEAR) ? '0 : im_wr;
    end
    re_rd_q   <= re_mem[bin_raddr];
    im_rd_q   <= im_mem[bin_raddr];
    s2_addr_q <= cnt_q;
  end

  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) begin
      hist_mem[cnt_q] <= '0;
    end else if (state_q == S_DELTA) begin
      hist_mem[idx_q] <= sample_q;
    end
    hist_rd_q <= hist_mem[idx_q];
    if (state_q == S_DELTA) begin
      delta_q <= $signed({1'b0, sample_q}) - $signed({1'b0, hist_rd_q});
    end
  end

  sdft_twiddle_rom #(
    .N_BINS (N_BINS),
    .TW_W   (TW_W),
    .AW     (AW)
  ) u_rom (
    .clk    (clk),
    .addr_i (cnt_q),
    .wr_o   (wr),
    .wi_o   (wi)
  );

  assign bus.ready    = (state_q == S_IDLE);
  assign bus.done     = done_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;

endmodule

`default_nettype wire
